// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions, used by the ALU and the ID/EX stage.
//   alumode_e    : ALU operation encodings
//   dsctl_t      : downstream control flags carried through EX
//   BUBBLE_MODE / BUBBLE_DSCTL : control values of an inserted bubble
//   *_DEF        : default datapath widths
package alu_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int CONTROLL_WIDTH_DEF = 4;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    SLT = 4'd5,
    JAL = 4'd8
  } alumode_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } dsctl_t;

  // A bubble must never write, touch memory, or compute anything but ADD.
  localparam alumode_e BUBBLE_MODE  = ADD;
  localparam dsctl_t   BUBBLE_DSCTL = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0};

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode -> ID/EX bundle.
//   id_*         : decoded instruction fields from the ID stage
//   hazard_stall : load-use indication back to fetch/decode
// Modports: master = decode side, slave = ID/EX stage.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = alu_pkg::DATA_WIDTH_DEF,
  parameter int CONTROLL_WIDTH = alu_pkg::CONTROLL_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = alu_pkg::REG_ADDR_WIDTH_DEF
);
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic                      id_alusrc;
  logic [CONTROLL_WIDTH-1:0] id_ctrl;
  logic                      id_regwrite;
  logic                      id_memread;
  logic                      id_memwrite;
  logic                      hazard_stall;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_uses_rs1, id_uses_rs2, id_alusrc, id_ctrl,
           id_regwrite, id_memread, id_memwrite,
    input  hazard_stall
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_uses_rs1, id_uses_rs2, id_alusrc, id_ctrl,
           id_regwrite, id_memread, id_memwrite,
    output hazard_stall
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: forwarding select for one source operand.
//   rs_addr / rf_data        : registered source index and register-file value
//   exmem_* / memwb_*        : writeback candidates from later stages
//   fwd_data                 : youngest matching value, else rf_data
// EX/MEM beats MEM/WB; x0 never matches.
module fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      exmem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);
  logic hit_exmem, hit_memwb;

  assign hit_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_addr);
  assign hit_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr);

  always_comb begin
    fwd_data = rf_data;
    if (hit_exmem)      fwd_data = exmem_result;
    else if (hit_memwb) fwd_data = memwb_result;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   clk, rst            : clock, synchronous active-high reset
//   id (slave)          : decoded instruction in, hazard_stall out
//   stall, flush        : downstream hold / redirect kill
//   exmem_*, memwb_*    : forwarding sources
//   ex_valid, op1, op2, ctrl, ex_store_data, ex_rd_addr,
//   ex_regwrite, ex_memread, ex_memwrite : EX-side outputs
// Optional: define ID_EX_PERF_CNT_EN for bubble_count / flush_count
// (32-bit saturating event counters).
// Update priority: rst > flush > stall > hazard_stall > load.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int CONTROLL_WIDTH = CONTROLL_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  id_ex_stage_if.slave              id,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      exmem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     op1,
  output logic [DATA_WIDTH-1:0]     op2,
  output logic [CONTROLL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                      ex_regwrite,
  output logic                      ex_memread,
`ifdef ID_EX_PERF_CNT_EN
  output logic                      ex_memwrite,
  output logic [31:0]               bubble_count,
  output logic [31:0]               flush_count
`else
  output logic                      ex_memwrite
`endif
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      alusrc;
    logic [CONTROLL_WIDTH-1:0] ctrl;
    dsctl_t                    dsctl;
  } idex_t;

  idex_t ex_q, id_d, bubble;
  logic  hazard;

  always_comb begin
    bubble       = '0;
    bubble.ctrl  = CONTROLL_WIDTH'(BUBBLE_MODE);
    bubble.dsctl = BUBBLE_DSCTL;
  end

  always_comb begin
    id_d                = '0;
    id_d.valid          = id.id_valid;
    id_d.rs1_data       = id.id_rs1_data;
    id_d.rs2_data       = id.id_rs2_data;
    id_d.imm            = id.id_imm;
    id_d.rs1_addr       = id.id_rs1_addr;
    id_d.rs2_addr       = id.id_rs2_addr;
    id_d.rd_addr        = id.id_rd_addr;
    id_d.alusrc         = id.id_alusrc;
    id_d.ctrl           = id.id_ctrl;
    id_d.dsctl.regwrite = id.id_regwrite;
    id_d.dsctl.memread  = id.id_memread;
    id_d.dsctl.memwrite = id.id_memwrite;
  end

  // Load in EX whose result a valid ID instruction needs right now.
  // Goes away by itself once the bubble replaces the load in EX.
  assign hazard = ex_q.valid && ex_q.dsctl.memread && (ex_q.rd_addr != '0) && id.id_valid &&
                  ((id.id_uses_rs1 && (id.id_rs1_addr == ex_q.rd_addr)) ||
                   (id.id_uses_rs2 && (id.id_rs2_addr == ex_q.rd_addr)));
  assign id.hazard_stall = hazard;

  always_ff @(posedge clk) begin
    if (rst)              ex_q <= '0;
    else if (flush)       ex_q <= bubble;   // kill wins even over a held stage
    else if (stall)       ex_q <= ex_q;
    else if (hazard)      ex_q <= bubble;
    else                  ex_q <= id_d;
  end

  // Per-operand forwarding; index 0 = rs1, 1 = rs2.
  logic [1:0][REG_ADDR_WIDTH-1:0] rs_addr;
  logic [1:0][DATA_WIDTH-1:0]     rs_rf, rs_fwd;

  assign rs_addr = {ex_q.rs2_addr, ex_q.rs1_addr};
  assign rs_rf   = {ex_q.rs2_data, ex_q.rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_mux #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd (
      .rs_addr        (rs_addr[g]),
      .rf_data        (rs_rf[g]),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .fwd_data       (rs_fwd[g])
    );
  end

  assign ex_valid      = ex_q.valid;
  assign op1           = rs_fwd[0];
  assign op2           = ex_q.alusrc ? ex_q.imm : rs_fwd[1];
  assign ex_store_data = rs_fwd[1];
  assign ctrl          = ex_q.ctrl;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_regwrite   = ex_q.dsctl.regwrite;
  assign ex_memread    = ex_q.dsctl.memread;
  assign ex_memwrite   = ex_q.dsctl.memwrite;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else if (flush) begin
      if (flush_count != '1) flush_count <= flush_count + 32'd1;
    end else if (!stall && hazard) begin
      if (bubble_count != '1) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with load-use hazard detection and operand forwarding; sits directly upstream of the ALU.
- Latches decoded operands and control from decode, then resolves forwarding from EX/MEM and MEM/WB.
- Drives op1, op2 and ctrl straight into the ALU. Inserts bubbles on load-use hazards and on flush.

Parameters:
- DATA_WIDTH, 32, operand/result width
- CONTROLL_WIDTH, 4, ALU ctrl width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- stall  in  1  downstream stall; hold ID/EX contents
- flush  in  1  branch/jump redirect; kill the instruction entering EX
- id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH  register file data and immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_WIDTH  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1/rs2
- id_alusrc  in  1  1 = op2 takes the immediate
- id_ctrl  in  CONTROLL_WIDTH  ALU mode
- id_regwrite, id_memread, id_memwrite  in  1  downstream control
- exmem_regwrite  in  1;  exmem_rd  in  REG_ADDR_WIDTH;  exmem_result  in  DATA_WIDTH
- memwb_regwrite  in  1;  memwb_rd  in  REG_ADDR_WIDTH;  memwb_result  in  DATA_WIDTH
- hazard_stall  out  1  load-use detected; fetch/decode must hold
- ex_valid  out  1  EX slot holds a real instruction
- op1, op2  out  DATA_WIDTH  ALU operands
- ctrl  out  CONTROLL_WIDTH  ALU mode
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, for stores
- ex_rd_addr  out  REG_ADDR_WIDTH;  ex_regwrite, ex_memread, ex_memwrite  out  1

Behaviour:
- Reset: all registered fields 0. ex_valid=0, ctrl=ADD(0), every control bit 0, ex_rd_addr=0. hazard_stall=0 follows because ex_valid=0.
- Register update per rising edge, priority rst > flush > stall > hazard_stall > load:
  - flush: load a bubble, even when stall=1.
  - stall=1 (no flush): hold all fields.
  - hazard_stall=1: load a bubble.
  - otherwise: capture all id_* inputs, with ex_valid<=id_valid.
- Bubble contents: valid=0, regwrite/memread/memwrite=0, rd=0, ctrl=ADD, data fields 0.
- hazard_stall is combinational: ex_valid & ex_memread & ex_rd_addr!=0 & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
  - Exactly one bubble per load-use; deasserts the next cycle once the load advances.
- Forwarding is combinational on the registered rs1/rs2 addresses, applied per operand:
  - Use exmem_result if exmem_regwrite & exmem_rd!=0 & exmem_rd==rs.
  - Else use memwb_result if memwb_regwrite & memwb_rd!=0 & memwb_rd==rs.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Outputs:
  - op1 = forwarded rs1.
  - op2 = registered alusrc ? registered imm : forwarded rs2.
  - ex_store_data = forwarded rs2, regardless of alusrc.
  - Total latency ID to ALU inputs: 1 cycle.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds output ports bubble_count and flush_count, each 32 bits wide, reset to 0.
  - bubble_count increments on each edge where hazard_stall loads a bubble.
  - flush_count increments on each edge where flush loads a bubble.
  - Both counters saturate at 0xFFFFFFFF and hold during stall.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - the alumodes enum: ADD=0, SUB=1, AND=2, OR=3, SLT=5, JAL=8;
  - default widths;
  - a bubble control constant.
  The ALU and this block both import it.
- Sub-module fwd_mux: one operand's forwarding select, instantiated twice (rs1, rs2).

Test Plan:
- Reset then plain load: rst 1 cycle, then id_valid=1, rs1_data=5, imm=7, alusrc=1, ctrl=ADD -> next cycle op1=5, op2=7, ctrl=0, ex_valid=1.
- Forwarding priority: registered rs1=3, exmem_rd=3 with result 0xAA, memwb_rd=3 with result 0xBB, both regwrite=1 -> op1=0xAA. Drop exmem_regwrite -> op1=0xBB. Set both rd=0 -> op1 = register data.
- Load-use: EX holds a memread with rd=4; ID uses rs2=4 -> hazard_stall=1 the same cycle. Next cycle ex_valid=0 and hazard_stall=0. Following cycle the dependent instruction is in EX with memwb forwarding.
- Flush vs stall: stall=1 and flush=1 together -> ex_valid=0, ex_regwrite=0 next cycle. stall=1 alone for 3 cycles -> all outputs constant.
- Store forwarding: alusrc=1, imm=16, rs2=6, exmem_rd=6 with result 0x1234 -> op2=16, ex_store_data=0x1234.
- ID_EX_PERF_CNT_EN defined: 2 load-use bubbles and 3 flushes -> bubble_count=2, flush_count=3. Reset -> both 0.
